// File: rtl/spw_axi_intr_ctrl.sv
// spw_axi_intr_ctrl: AXI4-Lite interrupt controller capturing SpaceWire event lines into a maskable ISR driving irq
module spw_axi_intr_ctrl #(
  parameter int          C_NUM_OF_INTR      = 1,
  parameter logic [31:0] C_INTR_SENSITIVITY = 32'hFFFFFFFF,
  parameter int          C_IRQ_ACTIVE_STATE = 1,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_NUM_OF_INTR-1:0]        intr_src,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);
  localparam int N = C_NUM_OF_INTR;
  localparam logic [N-1:0] L_SENS = C_INTR_SENSITIVITY[N-1:0];
  localparam logic L_ACT = C_IRQ_ACTIVE_STATE != 0;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t r_wstate, w_wnext;
  r_state_t r_rstate, w_rnext;
  logic w_wr, w_rd, r_gie, w_unused;
  logic [N-1:0] r_ier, r_isr, r_prev, w_set, w_ack, w_ipr;
  logic [31:0] w_bmask, w_rdata;
  logic [2:0] w_waddr, w_raddr;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  always_comb begin
    w_wnext = r_wstate == W_IDLE ? ((S_AXI_AWVALID && S_AXI_WVALID) ? W_RESP : W_IDLE)
                                 : (S_AXI_BREADY ? W_IDLE : W_RESP);
    w_rnext = r_rstate == R_IDLE ? (S_AXI_ARVALID ? R_DATA : R_IDLE)
                                 : (S_AXI_RREADY ? R_IDLE : R_DATA);
  end
  always_comb begin
    w_wr = r_wstate == W_IDLE && S_AXI_AWVALID && S_AXI_WVALID;
    w_rd = r_rstate == R_IDLE && S_AXI_ARVALID;
    S_AXI_AWREADY = w_wr;
    S_AXI_WREADY = w_wr;
    S_AXI_BVALID = r_wstate == W_RESP;
    S_AXI_ARREADY = w_rd;
    S_AXI_RVALID = r_rstate == R_DATA;
  end
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign w_waddr = S_AXI_AWADDR[4:2];
  assign w_raddr = S_AXI_ARADDR[4:2];
  assign w_bmask = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
  // edge sources fire only on 0->1 against the previous sample; level sources fire whenever high
  assign w_set = intr_src & ~(L_SENS & r_prev);
  assign w_ack = (w_wr && w_waddr == 3'd3) ? S_AXI_WDATA[N-1:0] & w_bmask[N-1:0] : '0;
  assign w_ipr = r_isr & r_ier;
  assign w_rdata = w_raddr == 3'd0 ? 32'(r_gie) :
                   w_raddr == 3'd1 ? 32'(r_ier) :
                   w_raddr == 3'd2 ? 32'(r_isr) :
                   w_raddr == 3'd4 ? 32'(w_ipr) : 32'd0;
  assign w_unused = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA};
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      r_gie <= 1'b0;
      r_ier <= '0;
      r_isr <= '0;
      r_prev <= '0;
      irq <= ~L_ACT;
      S_AXI_RDATA <= '0;
    end else begin
      r_prev <= intr_src;
      r_isr <= (r_isr & ~w_ack) | w_set;
      irq <= (r_gie && |w_ipr) ? L_ACT : ~L_ACT;
      if (w_wr && w_waddr == 3'd0 && S_AXI_WSTRB[0]) r_gie <= S_AXI_WDATA[0];
      if (w_wr && w_waddr == 3'd1) r_ier <= (r_ier & ~w_bmask[N-1:0]) | (S_AXI_WDATA[N-1:0] & w_bmask[N-1:0]);
      if (w_rd) S_AXI_RDATA <= w_rdata;
    end
endmodule

// File: tb/tb_spw_axi_intr_ctrl.sv
// tb_spw_axi_intr_ctrl: directed bench for the interrupt controller, with a per-cycle reference model
module tb_spw_axi_intr_ctrl;
  logic ACLK = 0, ARESETN = 0;
  logic [1:0] intr_src = 0;
  logic [4:0] AWADDR = 0, ARADDR = 0;
  logic AWVALID = 0, WVALID = 0, BREADY = 1, ARVALID = 0, RREADY = 1;
  logic [31:0] WDATA = 0;
  logic [3:0] WSTRB = 4'hF;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID, irq;
  logic [1:0] BRESP, RRESP;
  logic [31:0] RDATA;
  int checks = 0, errors = 0;

  spw_axi_intr_ctrl #(.C_NUM_OF_INTR(2), .C_INTR_SENSITIVITY(32'h1)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .intr_src(intr_src),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .irq(irq));

  always #5 ACLK = ~ACLK;

  function automatic void chk(input string n, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, g, e);
    end
  endfunction

  // reference model: src0 is an edge source, src1 a level source
  localparam logic [1:0] SENS_EDGE = 2'b01;
  logic m_gie, m_irq, m_bv, m_rv, m_wacc, m_racc;
  logic [1:0] m_ier, m_isr, m_prev, m_ack, m_set;
  logic [31:0] m_rdata, m_rd;

  always_comb begin
    m_wacc = !m_bv && AWVALID && WVALID;
    m_racc = !m_rv && ARVALID;
    m_ack = (m_wacc && AWADDR[4:2] == 3'd3 && WSTRB[0]) ? WDATA[1:0] : 2'b00;
    for (int i = 0; i < 2; i++)
      m_set[i] = SENS_EDGE[i] ? (intr_src[i] && !m_prev[i]) : intr_src[i];
    case (ARADDR[4:2])
      3'd0: m_rd = {31'b0, m_gie};
      3'd1: m_rd = {30'b0, m_ier};
      3'd2: m_rd = {30'b0, m_isr};
      3'd4: m_rd = {30'b0, m_isr & m_ier};
      default: m_rd = 32'd0;
    endcase
  end

  always @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      m_gie <= 0; m_ier <= 0; m_isr <= 0; m_prev <= 0; m_irq <= 0;
      m_bv <= 0; m_rv <= 0; m_rdata <= 0;
    end else begin
      m_prev <= intr_src;
      m_isr <= (m_isr & ~m_ack) | m_set;
      m_irq <= m_gie && ((m_isr & m_ier) != 2'b00);
      if (m_wacc && WSTRB[0] && AWADDR[4:2] == 3'd0) m_gie <= WDATA[0];
      if (m_wacc && WSTRB[0] && AWADDR[4:2] == 3'd1) m_ier <= WDATA[1:0];
      m_bv <= m_wacc ? 1'b1 : (BREADY ? 1'b0 : m_bv);
      m_rv <= m_racc ? 1'b1 : (RREADY ? 1'b0 : m_rv);
      if (m_racc) m_rdata <= m_rd;
    end

  always @(negedge ACLK) begin
    chk("irq", 32'(irq), 32'(m_irq));
    chk("awready", 32'(AWREADY), 32'(m_wacc));
    chk("wready", 32'(WREADY), 32'(m_wacc));
    chk("bvalid", 32'(BVALID), 32'(m_bv));
    chk("arready", 32'(ARREADY), 32'(m_racc));
    chk("rvalid", 32'(RVALID), 32'(m_rv));
    if (m_rv) chk("rdata", RDATA, m_rdata);
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    int n = 0;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 1;
    #1;
    while (!AWREADY && n < 20) begin step(); n++; end
    chk("aw_handshake", 32'(AWREADY), 32'd1);
    step();
    AWVALID = 0; WVALID = 0; WSTRB = 4'hF;
    n = 0;
    while (!BVALID && n < 20) begin step(); n++; end
    chk("bresp", {29'b0, BVALID, BRESP}, 32'h4);
    step();
  endtask

  task automatic rdchk(input string name, input logic [4:0] a, input logic [31:0] e);
    int n = 0;
    ARADDR = a; ARVALID = 1; RREADY = 1;
    #1;
    while (!ARREADY && n < 20) begin step(); n++; end
    chk("ar_handshake", 32'(ARREADY), 32'd1);
    step();
    ARVALID = 0;
    chk({name, "_rvalid_lat1"}, 32'(RVALID), 32'd1);
    n = 0;
    while (!RVALID && n < 20) begin step(); n++; end
    chk(name, RDATA, e);
    chk({name, "_rresp"}, 32'(RRESP), 32'd0);
    step();
  endtask

  initial begin
    int awn, arn;
    logic got;
    logic [31:0] first;
    repeat (20) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1;
    for (int i = 0; i < 5; i++) rdchk("rst_read", 5'(4 * i), 32'd0);
    chk("irq_idle", 32'(irq), 32'd0);

    wr(5'h00, 32'd1);
    wr(5'h04, 32'd1);
    intr_src = 2'b01; step(); intr_src = 2'b00;
    step();
    chk("edge_irq_2cyc", 32'(irq), 32'd1);
    rdchk("edge_ipr", 5'h10, 32'd1);
    rdchk("edge_isr", 5'h08, 32'd1);
    wr(5'h0C, 32'd1);
    chk("ack_irq_off", 32'(irq), 32'd0);
    rdchk("ack_ipr", 5'h10, 32'd0);

    wr(5'h04, 32'd0);
    intr_src = 2'b01; step(); intr_src = 2'b00;
    step(); step();
    chk("mask_irq_off", 32'(irq), 32'd0);
    rdchk("mask_isr", 5'h08, 32'd1);
    rdchk("mask_ipr", 5'h10, 32'd0);
    wr(5'h04, 32'd1);
    chk("unmask_irq_on", 32'(irq), 32'd1);
    wr(5'h0C, 32'd1);
    chk("unmask_ack_off", 32'(irq), 32'd0);

    intr_src = 2'b01; step(); intr_src = 2'b00; step();
    intr_src = 2'b01;
    wr(5'h0C, 32'd1);
    intr_src = 2'b00;
    rdchk("collide_isr", 5'h08, 32'd1);
    chk("collide_irq", 32'(irq), 32'd1);
    wr(5'h0C, 32'd1);
    rdchk("collide_clr", 5'h08, 32'd0);

    wr(5'h04, 32'd3);
    intr_src = 2'b10; step();
    rdchk("level_isr", 5'h08, 32'd2);
    wr(5'h0C, 32'd2);
    rdchk("level_reset", 5'h08, 32'd2);
    intr_src = 2'b00; step();
    wr(5'h0C, 32'd2);
    rdchk("level_clr", 5'h08, 32'd0);
    rdchk("level_ipr", 5'h10, 32'd0);

    wr(5'h04, 32'd0, 4'b1110);
    rdchk("wstrb_ier", 5'h04, 32'd3);
    wr(5'h04, 32'hFFFF_FFFC);
    rdchk("upper_ier", 5'h04, 32'd0);
    wr(5'h04, 32'hFFFF_FFFF);
    rdchk("full_ier", 5'h04, 32'd3);
    wr(5'h14, 32'hFFFF_FFFF);
    rdchk("unmapped14", 5'h14, 32'd0);
    rdchk("unmapped1c", 5'h1C, 32'd0);
    rdchk("iack_read", 5'h0C, 32'd0);
    rdchk("gie_kept", 5'h00, 32'd1);

    BREADY = 0; RREADY = 0;
    AWADDR = 5'h00; WDATA = 32'd0; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 5'h00; ARVALID = 1;
    awn = 0; arn = 0; got = 0; first = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      awn += int'(AWREADY);
      arn += int'(ARREADY);
      if (RVALID) begin
        if (!got) begin first = RDATA; got = 1; end
        else chk("stall_rdata_stable", RDATA, first);
      end
      step();
    end
    chk("stall_aw_once", 32'(awn), 32'd1);
    chk("stall_ar_once", 32'(arn), 32'd1);
    chk("stall_pre_write_gie", first, 32'd1);
    chk("stall_bvalid", 32'(BVALID), 32'd1);
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
    step();
    chk("stall_bvalid_done", 32'(BVALID), 32'd0);
    chk("stall_rvalid_done", 32'(RVALID), 32'd0);
    rdchk("gie_cleared", 5'h00, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
